mux_nway_stream: RTL and testbench

- Parametrised N-way, W-bit multiplexor with a valid/ready handshake on every input channel and on the output, and a registered output stage.
- Generalises the fixed 8-way 16-bit combinational mux:
  - channel count and data width are parameters;
  - the channel is chosen either by explicit select or by round-robin arbitration;
  - throughput is one word per cycle, with back-pressure.
- Sits between multiple producers (e.g. register-file read ports, memory-mapped sources) and a single consumer.

---
 rtl/mux_nway_stream_pkg.sv | 13 +
 rtl/mux_nway_stream_if.sv | 31 +++
 rtl/mux_nway_stream_rr_pick.sv | 35 +++
 rtl/mux_nway_stream.sv | 97 +++++++++
 tb/tb_mux_nway_stream.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/mux_nway_stream_pkg.sv
// Shared constants and helpers for the N-way streaming multiplexor.
package mux_nway_stream_pkg;

    // Channel-choice modes.
    localparam int MUX_MODE_SEL = 0;
    localparam int MUX_MODE_RR  = 1;

    // Width of a channel index; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_nway_stream_if.sv
// Bundle of the producer-side and consumer-side handshake signals.
interface mux_nway_stream_if
    import mux_nway_stream_pkg::*;
#(
    parameter int N     = 8,
    parameter int W     = 16,
    parameter int SEL_W = idx_w(N)
);

    logic [N*W-1:0]   in_data_i;
    logic [N-1:0]     in_valid_i;
    logic [N-1:0]     in_ready_o;
    logic [SEL_W-1:0] sel_i;
    logic [W-1:0]     out_data_o;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [SEL_W-1:0] out_chan_o;

    // Environment side: producers, select source and consumer.
    modport master (
        output in_data_i, in_valid_i, sel_i, out_ready_i,
        input  in_ready_o, out_data_o, out_valid_o, out_chan_o
    );

    // Multiplexor side.
    modport slave (
        input  in_data_i, in_valid_i, sel_i, out_ready_i,
        output in_ready_o, out_data_o, out_valid_o, out_chan_o
    );

endinterface

// File: rtl/mux_nway_stream_rr_pick.sv
// Rotating priority encoder: first requesting channel at or after ptr, wrapping at N-1.
module mux_nway_stream_rr_pick #(
    parameter int N     = 8,
    parameter int SEL_W = 3
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             grant_valid,
    output logic [SEL_W-1:0] grant_idx
);

    logic [2*N-1:0]   req_dbl;
    logic [N-1:0]     req_rot;
    logic [SEL_W-1:0] off;
    logic [SEL_W:0]   sum;

    // Doubling the request vector turns the rotation into a plain slice starting at ptr.
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[ptr +: N];

    // Lowest set bit of the rotated vector is the winner's distance from ptr.
    always_comb begin
        grant_valid = 1'b0;
        off         = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                grant_valid = 1'b1;
                off         = SEL_W'(i);
            end
        end
        sum       = {1'b0, ptr} + {1'b0, off};
        grant_idx = (sum >= (SEL_W+1)'(N)) ? SEL_W'(sum - (SEL_W+1)'(N)) : SEL_W'(sum);
    end

endmodule

// File: rtl/mux_nway_stream.sv
// N-way W-bit multiplexor with per-channel valid/ready and a registered output stage.
// Channel choice is an explicit select (MODE 0) or round-robin over valid inputs (MODE 1).
// out_ready_i reaches in_ready_o combinationally; there is no skid buffer here.
module mux_nway_stream
    import mux_nway_stream_pkg::*;
#(
    parameter int N    = 8,
    parameter int W    = 16,
    parameter int MODE = MUX_MODE_SEL
) (
    input  logic               clk_i,
    input  logic               rst_i,
    mux_nway_stream_if.slave   bus
);

    localparam int SEL_W = idx_w(N);

    logic             load;
    logic             pick_vld;
    logic [SEL_W-1:0] pick_idx;
    logic             chan_vld;
    logic             xfer;
    logic [W-1:0]     pick_data;
    logic [N-1:0]     ready_dec;

    logic             vld_p1;
    logic [W-1:0]     data_p1;
    logic [SEL_W-1:0] chan_p1;

    // ---- stage 0: channel choice, ready decode, transfer ----
    if (MODE == MUX_MODE_RR) begin : g_rr
        logic [SEL_W-1:0] ptr;
        logic             sel_unused;

        // The select input has no role under arbitration.
        assign sel_unused = ^bus.sel_i;

        mux_nway_stream_rr_pick #(
            .N     (N),
            .SEL_W (SEL_W)
        ) u_pick (
            .req         (bus.in_valid_i),
            .ptr         (ptr),
            .grant_valid (pick_vld),
            .grant_idx   (pick_idx)
        );

        // Pointer moves just past the channel that last transferred.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                ptr <= '0;
            end else if (xfer) begin
                ptr <= (pick_idx == SEL_W'(N - 1)) ? '0 : pick_idx + SEL_W'(1);
            end
        end
    end else begin : g_sel
        // Select codes at or above N (non power-of-two N) choose nothing.
        assign pick_vld = (int'(bus.sel_i) < N);
        assign pick_idx = bus.sel_i;
    end

    assign load      = !vld_p1 || bus.out_ready_i;
    assign chan_vld  = pick_vld && bus.in_valid_i[pick_idx];
    assign xfer      = load && chan_vld && !rst_i;
    assign pick_data = bus.in_data_i[pick_idx*W +: W];

    // One-hot ready toward the chosen channel, only when its word can be taken.
    always_comb begin
        ready_dec = '0;
        if (xfer) begin
            ready_dec[pick_idx] = 1'b1;
        end
    end

    assign bus.in_ready_o = ready_dec;

    // ---- stage 1: output register ----
    // Load on transfer, drop valid on an empty load, hold everything while stalled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            chan_p1 <= '0;
        end else if (load) begin
            vld_p1 <= xfer;
            if (xfer) begin
                data_p1 <= pick_data;
                chan_p1 <= pick_idx;
            end
        end
    end

    assign bus.out_valid_o = vld_p1;
    assign bus.out_data_o  = data_p1;
    assign bus.out_chan_o  = chan_p1;

endmodule

// File: tb/tb_mux_nway_stream.sv
// Bench for mux_nway_stream: three instances (N=8 select, N=8 round-robin, N=5 select)
// driven from one stimulus process and checked by a queue-based scoreboard.
module tb_mux_nway_stream;

    localparam int ND = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Stimulus-side arrays, one slot per instance (sized for the widest instance).
    logic [127:0] in_data_all  [ND];
    logic [7:0]   in_valid_all [ND];
    logic [2:0]   sel_all      [ND];
    logic         out_ready_all[ND];

    // Observed DUT outputs.
    logic [7:0]   in_ready_all [ND];
    logic [15:0]  out_data_all [ND];
    logic         out_valid_all[ND];
    logic [2:0]   out_chan_all [ND];

    int cfg_n    [ND] = '{8, 8, 5};
    int cfg_mode [ND] = '{0, 1, 0};

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int GN = (g == 2) ? 5 : 8;
        localparam int GM = (g == 1) ? 1 : 0;

        mux_nway_stream_if #(.N(GN), .W(16)) bus ();

        assign bus.in_data_i   = in_data_all[g][GN*16-1:0];
        assign bus.in_valid_i  = in_valid_all[g][GN-1:0];
        assign bus.sel_i       = sel_all[g];
        assign bus.out_ready_i = out_ready_all[g];

        assign in_ready_all[g]  = 8'(bus.in_ready_o);
        assign out_data_all[g]  = bus.out_data_o;
        assign out_valid_all[g] = bus.out_valid_o;
        assign out_chan_all[g]  = bus.out_chan_o;

        mux_nway_stream #(.N(GN), .W(16), .MODE(GM)) dut (
            .clk_i (clk),
            .rst_i (rst),
            .bus   (bus)
        );
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int g, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s dut%0d actual=0x%0h required=0x%0h at %0t", name, g, act, req, $time);
        end
    endtask

    // Reference model: the words expected in each output register, and the arbitration pointer.
    logic [18:0] exp_q [ND][$];
    int          ptr_m [ND];
    logic        m_had, m_load, m_chosen, m_xfer;
    int          m_c, m_k;

    // Monitor: on the falling edge, compare outputs and ready, then predict the next rising edge.
    always @(negedge clk) begin
        for (int g = 0; g < ND; g++) begin
            if (rst) begin
                check("rst_out_valid", g, 32'(out_valid_all[g]), 32'd0);
                check("rst_out_data",  g, 32'(out_data_all[g]),  32'd0);
                check("rst_out_chan",  g, 32'(out_chan_all[g]),  32'd0);
                check("rst_in_ready",  g, 32'(in_ready_all[g]),  32'd0);
                exp_q[g].delete();
                ptr_m[g] = 0;
            end else begin
                m_had = (exp_q[g].size() != 0);
                check("out_valid", g, 32'(out_valid_all[g]), 32'(m_had));
                if (m_had) begin
                    check("out_data", g, 32'(out_data_all[g]), 32'(exp_q[g][0][18:3]));
                    check("out_chan", g, 32'(out_chan_all[g]), 32'(exp_q[g][0][2:0]));
                    if (out_ready_all[g]) void'(exp_q[g].pop_front());
                end
                m_load   = !m_had || out_ready_all[g];
                m_chosen = 1'b0;
                m_c      = 0;
                if (cfg_mode[g] == 0) begin
                    if (int'(sel_all[g]) < cfg_n[g]) begin
                        m_chosen = 1'b1;
                        m_c      = int'(sel_all[g]);
                    end
                end else begin
                    for (int i = 0; i < cfg_n[g]; i++) begin
                        m_k = (ptr_m[g] + i) % cfg_n[g];
                        if (!m_chosen && in_valid_all[g][m_k]) begin
                            m_chosen = 1'b1;
                            m_c      = m_k;
                        end
                    end
                end
                m_xfer = m_load && m_chosen && in_valid_all[g][m_c];
                check("in_ready", g, 32'(in_ready_all[g]), m_xfer ? (32'd1 << m_c) : 32'd0);
                if (m_xfer) begin
                    exp_q[g].push_back({in_data_all[g][m_c*16 +: 16], 3'(m_c)});
                    if (cfg_mode[g] == 1) ptr_m[g] = (m_c + 1) % cfg_n[g];
                end
            end
        end
    end

    function automatic logic [127:0] ramp(input logic [15:0] base);
        logic [127:0] r;
        for (int k = 0; k < 8; k++) r[k*16 +: 16] = base + 16'(k);
        return r;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_inputs();
        for (int g = 0; g < ND; g++) begin
            in_data_all[g]   = {$urandom, $urandom, $urandom, $urandom};
            in_valid_all[g]  = 8'($urandom);
            sel_all[g]       = 3'($urandom_range(0, 7));
            out_ready_all[g] = ($urandom_range(0, 3) != 0);
        end
    endtask

    // Stimulus: directed scenarios first, then randomized traffic, a mid-stall reset, more traffic.
    initial begin
        rst = 1'b1;
        for (int g = 0; g < ND; g++) begin
            in_data_all[g]   = '0;
            in_valid_all[g]  = '0;
            sel_all[g]       = '0;
            out_ready_all[g] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Full-rate sweep: select 0..7,0 on dut0/dut2; round-robin over all channels on dut1.
        for (int i = 0; i < 9; i++) begin
            in_data_all[0] = ramp(16'h1000);
            in_data_all[1] = ramp(16'h2000);
            in_data_all[2] = ramp(16'h3000);
            in_valid_all[0] = 8'hFF;
            in_valid_all[1] = 8'hFF;
            in_valid_all[2] = 8'h1F;
            sel_all[0] = 3'(i % 8);
            sel_all[2] = 3'(i % 8);
            for (int g = 0; g < ND; g++) out_ready_all[g] = 1'b1;
            next_cycle();
        end

        // Stall with a select change on dut0; sparse requests and pointer wrap on dut1;
        // out-of-range select on dut2.
        for (int i = 0; i < 7; i++) begin
            in_data_all[0] = ramp(16'h1000);
            in_data_all[0][3*16 +: 16] = 16'hABCD;
            sel_all[0]       = (i == 0) ? 3'd3 : 3'd5;
            out_ready_all[0] = !(i >= 1 && i <= 4);
            in_valid_all[1]  = (i < 4) ? 8'h44 : 8'h82;
            sel_all[2]       = 3'd6;
            in_valid_all[2]  = 8'h1F;
            next_cycle();
        end

        for (int i = 0; i < 300; i++) begin
            randomize_inputs();
            next_cycle();
        end

        // Fill the output registers, stall, then reset asynchronously mid-stall.
        for (int g = 0; g < ND; g++) begin
            in_valid_all[g]  = 8'hFF;
            sel_all[g]       = 3'd2;
            out_ready_all[g] = 1'b1;
        end
        next_cycle();
        for (int g = 0; g < ND; g++) out_ready_all[g] = 1'b0;
        next_cycle();
        next_cycle();
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        for (int g = 0; g < ND; g++) begin
            in_data_all[g]   = ramp(16'h4000);
            in_valid_all[g]  = 8'hFF;
            out_ready_all[g] = 1'b1;
        end
        for (int i = 0; i < 4; i++) next_cycle();

        for (int i = 0; i < 200; i++) begin
            randomize_inputs();
            next_cycle();
        end

        for (int g = 0; g < ND; g++) begin
            in_valid_all[g]  = '0;
            out_ready_all[g] = 1'b1;
        end
        repeat (3) next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
